// File: rtl/emu_dut_pkg.sv
// Shared sizing and types for the emulation-instrumented memory wrapper.
// Also provides the mapping from a memory entry to its scan words.
package emu_dut_pkg;

  localparam int DEPTH     = 8;
  localparam int DWIDTH    = 80;
  localparam int SWIDTH    = 64;
  localparam int FF_WORDS  = (DWIDTH + SWIDTH - 1) / SWIDTH;
  localparam int MEM_WORDS = DEPTH * FF_WORDS;
  localparam int AW        = $clog2(DEPTH);
  localparam int KW        = $clog2(MEM_WORDS) + 1;
  localparam int HW        = DWIDTH - SWIDTH;
  localparam int PW        = SWIDTH - HW;

  typedef logic [AW-1:0]     addr_t;
  typedef logic [DWIDTH-1:0] data_t;
  typedef logic [SWIDTH-1:0] word_t;
  typedef logic [KW-1:0]     cnt_t;
  typedef logic [PW-1:0]     pad_t;

  localparam cnt_t K_END = cnt_t'(MEM_WORDS);

  function automatic word_t ram_word(data_t d, logic hi);
    return hi ? word_t'(d[DWIDTH-1:SWIDTH])
              : d[SWIDTH-1:0];
  endfunction

endpackage

// File: rtl/emu_dut_clock_gate.sv
// Glitch-free clock gate: enable is captured by a latch while clk is low.
// Ports: clk_i free clock, en_i enable, gclk_o gated clock.
module clock_gate (
  input  logic clk_i,
  input  logic en_i,
  output logic gclk_o
);

  logic en_q;

  always_latch begin
    if (!clk_i) en_q <= en_i;
  end

  assign gclk_o = clk_i & en_q;

endmodule

// File: rtl/emu_dut.sv
// 8x80 memory with registered read, FF scan chain and RAM scan chain.
// Ports: clk/rst_n, pause, ff_se/ff_di/ff_do, ram_se/ram_sd/ram_di/ram_do,
//        raddr/rdata read port, wen/waddr/wdata write port.
module emu_dut
  import emu_dut_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pause,
  input  logic              ff_se,
  input  logic [SWIDTH-1:0] ff_di,
  output logic [SWIDTH-1:0] ff_do,
  input  logic              ram_se,
  input  logic              ram_sd,
  input  logic [SWIDTH-1:0] ram_di,
  output logic [SWIDTH-1:0] ram_do,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata,
  input  logic              wen,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata
);

  logic ff_clk;
  logic ram_clk;

  clock_gate u_ff_cg (
    .clk_i  (clk),
    .en_i   (!pause || ff_se),
    .gclk_o (ff_clk)
  );

  clock_gate u_ram_cg (
    .clk_i  (clk),
    .en_i   (!pause || ram_se),
    .gclk_o (ram_clk)
  );

  logic func_en;
  assign func_en = !pause && !ff_se && !ram_se;

  data_t mem_q [DEPTH];

  // Read register and FF chain.
  // w1 is a full scan word: its upper bits live in pad_q, which is
  // zero outside a shift sequence, so a loopback dump is lossless.
  data_t rdata_q, rdata_d;
  pad_t  pad_q, pad_d;

  always_comb begin
    rdata_d = rdata_q;
    pad_d   = pad_q;
    if (ff_se) begin
      rdata_d = {ff_di[HW-1:0], pad_q,
                 rdata_q[DWIDTH-1:SWIDTH]};
      pad_d   = ff_di[SWIDTH-1:HW];
    end else if (func_en) begin
      rdata_d = mem_q[raddr];
      pad_d   = '0;
    end
  end

  always_ff @(posedge ff_clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      pad_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      pad_q   <= pad_d;
    end
  end

  assign rdata = rdata_q;
  assign ff_do = rdata_q[SWIDTH-1:0];

  // RAM scan counter runs on the free clock so it clears
  // even while the memory clock is gated off.
  cnt_t  k_q;
  logic  k_live;
  addr_t k_addr;
  logic  k_hi;

  assign k_live = ram_se && (k_q != K_END);
  assign k_addr = k_q[AW:1];
  assign k_hi   = k_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
    end else if (!ram_se) begin
      k_q <= '0;
    end else if (k_live) begin
      k_q <= k_q + cnt_t'(1);
    end
  end

  // Memory array: scan load wins over a functional write.
  always_ff @(posedge ram_clk) begin
    if (ram_se) begin
      if (ram_sd && k_live) begin
        if (k_hi)
          mem_q[k_addr][DWIDTH-1:SWIDTH] <= ram_di[HW-1:0];
        else
          mem_q[k_addr][SWIDTH-1:0] <= ram_di;
      end
    end else if (func_en && wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Two-stage dump pipeline: read register, then output register.
  logic  dv_q;
  word_t dw_q;
  word_t ram_do_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q     <= 1'b0;
      dw_q     <= '0;
      ram_do_q <= '0;
    end else begin
      dv_q     <= k_live && !ram_sd;
      dw_q     <= ram_word(mem_q[k_addr], k_hi);
      ram_do_q <= dv_q ? dw_q : '0;
    end
  end

  assign ram_do = ram_do_q;

endmodule

// File: tb/tb_emu_dut.sv
// Directed bench for emu_dut: functional access, FF/RAM scan
// save and restore, pause freeze and scan priority.
module tb_emu_dut;
  import emu_dut_pkg::*;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        pause  = 1'b0;
  logic        ff_se  = 1'b0;
  logic        ram_se = 1'b0;
  logic        ram_sd = 1'b0;
  logic        wen    = 1'b0;
  logic [63:0] ff_di  = '0;
  logic [63:0] ram_di = '0;
  logic [79:0] wdata  = '0;
  logic [2:0]  raddr  = '0;
  logic [2:0]  waddr  = '0;
  logic [63:0] ff_do;
  logic [63:0] ram_do;
  logic [79:0] rdata;

  int n_chk = 0;
  int n_err = 0;

  data_t mdl  [8];
  word_t sff  [5][2];
  word_t sram [5][16];
  data_t smem [5][8];
  data_t srd  [5];

  always #5 clk = ~clk;

  emu_dut dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pause  (pause),
    .ff_se  (ff_se),
    .ff_di  (ff_di),
    .ff_do  (ff_do),
    .ram_se (ram_se),
    .ram_sd (ram_sd),
    .ram_di (ram_di),
    .ram_do (ram_do),
    .raddr  (raddr),
    .rdata  (rdata),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata)
  );

  task automatic check_eq(input string tag,
                          input logic [79:0] got,
                          input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic data_t rnd();
    data_t v;
    v = {16'($urandom), $urandom, $urandom};
    return v;
  endfunction

  task automatic wr(input logic [2:0] a, input data_t d);
    wen   = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    wen   = 1'b0;
    mdl[a] = d;
  endtask

  task automatic fill();
    for (int a = 0; a < 8; a++) wr(3'(a), rnd());
  endtask

  task automatic rd_chk(input string tag);
    for (int a = 0; a < 8; a++) begin
      raddr = 3'(a);
      tick();
      check_eq($sformatf("%s[%0d]", tag, a), rdata, mdl[a]);
    end
  endtask

  task automatic ff_dump(input int r, input data_t e);
    word_t ew;
    ff_se = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ff_di = ff_do;
      ew = (i == 0) ? e[63:0] : word_t'(e[79:64]);
      check_eq($sformatf("ff_dump%0d_w%0d", r, i), ff_do, ew);
      sff[r][i] = ff_do;
      tick();
    end
    ff_se = 1'b0;
    ff_di = '0;
    check_eq($sformatf("ff_keep%0d", r), rdata, e);
    srd[r] = e;
  endtask

  task automatic ram_dump(input int r);
    word_t ew;
    ram_se = 1'b1;
    ram_sd = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      ew = (i % 2 == 1) ? word_t'(mdl[i/2][79:64])
                        : mdl[i/2][63:0];
      check_eq($sformatf("ram_dump%0d_w%0d", r, i), ram_do, ew);
      sram[r][i] = ram_do;
      smem[r][i/2] = mdl[i/2];
      tick();
    end
    check_eq($sformatf("ram_idle%0d", r), ram_do, '0);
    ram_se = 1'b0;
  endtask

  task automatic save(input int r);
    data_t e;
    pause = 1'b0;
    fill();
    raddr = 3'($urandom_range(0, 7));
    tick();
    e = mdl[raddr];
    pause = 1'b1;
    tick();
    ff_dump(r, e);
    ram_dump(r);
    check_eq($sformatf("ram_rd_keep%0d", r), rdata, e);
  endtask

  task automatic restore(input int r);
    pause = 1'b0;
    fill();
    raddr = 3'(r);
    tick();
    pause = 1'b1;
    ff_se = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ff_di = sff[r][i];
      tick();
    end
    ff_se = 1'b0;
    ff_di = '0;
    ram_se = 1'b1;
    ram_sd = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ram_di = (i < 16) ? sram[r][i] : 64'hdead_beef_cafe_f00d;
      tick();
    end
    ram_se = 1'b0;
    ram_sd = 1'b0;
    ram_di = '0;
    pause  = 1'b0;
    check_eq($sformatf("rst_rdata%0d", r), rdata, srd[r]);
    for (int a = 0; a < 8; a++) mdl[a] = smem[r][a];
    rd_chk($sformatf("rst_mem%0d", r));
  endtask

  initial begin
    data_t d;
    data_t e;
    tick();
    tick();
    check_eq("rst_rdata", rdata, '0);
    check_eq("rst_ff_do", ff_do, '0);
    check_eq("rst_ram_do", ram_do, '0);
    rst_n = 1'b1;
    tick();

    wr(3'd1, 80'h1234_5678_9abc_def0_1122);
    raddr = 3'd1;
    tick();
    check_eq("first_read", rdata, 80'h1234_5678_9abc_def0_1122);

    fill();
    rd_chk("fill");

    d = rnd();
    raddr = 3'd2;
    wen   = 1'b1;
    waddr = 3'd2;
    wdata = d;
    tick();
    wen = 1'b0;
    check_eq("raw_old", rdata, mdl[2]);
    mdl[2] = d;
    tick();
    check_eq("raw_new", rdata, d);

    save(4);
    restore(4);

    for (int r = 0; r < 4; r++) save(r);
    for (int r = 0; r < 4; r++) restore(r);

    pause = 1'b0;
    raddr = 3'd4;
    tick();
    e = mdl[4];
    raddr  = 3'd6;
    ram_se = 1'b1;
    ram_sd = 1'b0;
    wen    = 1'b1;
    waddr  = 3'd6;
    wdata  = rnd();
    tick();
    ram_se = 1'b0;
    wen    = 1'b0;
    check_eq("prio_hold", rdata, e);
    tick();
    check_eq("prio_nowr", rdata, mdl[6]);

    pause = 1'b1;
    wen   = 1'b1;
    waddr = 3'd3;
    wdata = rnd();
    for (int i = 0; i < 3; i++) begin
      raddr = 3'(i);
      tick();
      check_eq($sformatf("pause_hold%0d", i), rdata, mdl[6]);
    end
    pause = 1'b0;
    wen   = 1'b0;
    raddr = 3'd3;
    tick();
    check_eq("pause_nowr", rdata, mdl[3]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
